conv_psum_collector: RTL and testbench
======================================

CONV_PSUM_COLLECTOR -- requirements
Module: conv_psum_collector

Interface
REQ-001 SHALL have parameter LANES, default 24, meaning psum lanes per PE-array output word.
REQ-002 SHALL have parameter PSUM_W, default 20, meaning signed width of each incoming psum lane.
REQ-003 SHALL have parameter ACC_W, default 24, meaning signed width of each accumulator and output sample.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port psum_valid  input  1  psum_in beat valid.
REQ-007 SHALL have port psum_in  input  LANES*PSUM_W  PE-array psum word; lane i = bits [i*PSUM_W+PSUM_W-1 : i*PSUM_W].
REQ-008 SHALL have port first_ch  input  1  beat is the first input channel of a group (load, do not add).
REQ-009 SHALL have port last_ch  input  1  beat is the last input channel of a group (row complete).
REQ-010 SHALL have port psum_ready  output  1  collector accepts psum beats.
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data.
REQ-013 SHALL have port out_data  output  ACC_W  one accumulated lane, signed.
REQ-014 SHALL have port out_idx  output  5  lane index of out_data.
REQ-015 SHALL have port out_last  output  1  high with final lane (index LANES-1) of a row.
REQ-016 SHALL have port drop_err  output  1  sticky: a psum beat arrived while psum_ready was low.
REQ-017 SHALL have port sat_flag  output  1  sticky: any accumulator saturated.

Function
REQ-018 SHALL implement a two-state FSM: ACCUM (psum_ready=1, out_valid=0) and DRAIN (psum_ready=0, out_valid=1).
REQ-019 In ACCUM, on psum_valid with first_ch=1, SHALL load acc[i] = sign-extended psum lane i, for all lanes.
REQ-020 In ACCUM, on psum_valid with first_ch=0, SHALL set acc[i] = acc[i] + sign-extended lane i, saturated to signed ACC_W range (max 2^(ACC_W-1)-1, min -2^(ACC_W-1)), and set sat_flag if any lane clamps.
REQ-021 In ACCUM, on accepted beat with last_ch=1, SHALL move to DRAIN next cycle with idx=0; out_valid rises exactly one cycle after the last_ch beat.
REQ-022 first_ch=1 and last_ch=1 on one beat SHALL load and then drain (single-channel group).
REQ-023 In DRAIN, out_data SHALL present acc[idx], out_idx=idx, out_last=(idx==LANES-1); values held stable while out_ready=0.
REQ-024 In DRAIN, on out_ready=1, SHALL increment idx; when idx==LANES-1 is accepted, SHALL return to ACCUM with idx=0 on the next cycle.
REQ-025 psum_valid while in DRAIN SHALL be ignored (accumulators unchanged) and SHALL set drop_err.
REQ-026 psum_valid=0 SHALL leave all state unchanged; first_ch/last_ch are ignored when psum_valid=0.
REQ-027 Accumulators SHALL not be cleared on return to ACCUM; a group not starting with first_ch=1 adds onto the previous row's values.

Reset
REQ-028 On rst high SHALL immediately force: state ACCUM, idx 0, all acc 0, psum_ready 1, out_valid 0, out_data 0, out_idx 0, out_last 0, drop_err 0, sat_flag 0.
REQ-029 Reset asserted mid-DRAIN SHALL abandon the row; after release the first output occurs only after a new last_ch beat.

Configuration
REQ-030 With macro PSUM_RELU_EN defined, out_data SHALL be 0 whenever acc[idx] is negative (accumulators themselves unchanged); without it, out_data SHALL equal acc[idx] unmodified.

Verification
REQ-031 Beat lanes all +5 with first_ch=1, then all +3 with last_ch=1, out_ready=1 -> 24 outputs of 8, out_idx 0..23, out_last only at 23, psum_ready low exactly 24 cycles.
REQ-032 Lane 0 = -1000 with first_ch=last_ch=1 -> out_data 0 at idx 0 with PSUM_RELU_EN, -1000 without.
REQ-033 Three beats, all lanes +2^19-1 (524287), first_ch on first, last_ch on third -> no saturation, out_data 1572861; then 20 beats of 524287 -> out_data 8388607, sat_flag=1.
REQ-034 out_ready toggled 1,0,0,1,... during drain -> out_data/out_idx stable while low, no lane skipped or repeated.
REQ-035 psum_valid pulsed during DRAIN -> drop_err=1 and sticky, drained values unchanged.
REQ-036 rst asserted at drain idx 10 -> outputs zero immediately, out_valid stays 0 until next last_ch beat.

Source files
------------

// File: rtl/conv_psum_collector.sv
// conv_psum_collector
//   Collects partial-sum words from a PE array and accumulates each lane
//   across the input channels of a group. When the group's last channel has
//   been accepted, the accumulated row is drained one lane per handshake.
//
//   Optional feature macro: PSUM_RELU_EN
//     defined   -> drained samples are clamped at zero (ReLU). The stored
//                  accumulators are left untouched.
//     undefined -> drained samples equal the accumulators unmodified.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   psum_valid  psum_in beat valid
//   psum_in     LANES lanes of signed PSUM_W psums, lane i at [i*PSUM_W +: PSUM_W]
//   first_ch    beat is the first channel of a group (load instead of add)
//   last_ch     beat is the last channel of a group (row complete)
//   psum_ready  high while beats are accepted (ACCUM state)
//   out_valid   high while a drained sample is presented (DRAIN state)
//   out_ready   downstream accepts out_data
//   out_data    accumulated lane out_idx, signed ACC_W
//   out_idx     lane index of out_data
//   out_last    high with lane LANES-1
//   drop_err    sticky: a beat arrived while psum_ready was low
//   sat_flag    sticky: an accumulator saturated
module conv_psum_collector #(
   parameter int LANES  = 24,
   parameter int PSUM_W = 20,
   parameter int ACC_W  = 24
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      psum_valid,
   input  logic [LANES*PSUM_W-1:0]   psum_in,
   input  logic                      first_ch,
   input  logic                      last_ch,
   output logic                      psum_ready,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [ACC_W-1:0]          out_data,
   output logic [4:0]                out_idx,
   output logic                      out_last,
   output logic                      drop_err,
   output logic                      sat_flag
);

   localparam logic [0:0] ST_ACCUM = 1'b0;
   localparam logic [0:0] ST_DRAIN = 1'b1;
   localparam logic [4:0] LAST_IDX = 5'(LANES - 1);

   logic [0:0]              state_q, state_d;
   logic [4:0]              idx_q, idx_d;
   logic [ACC_W-1:0]        acc_q [LANES];
   logic [ACC_W-1:0]        acc_d [LANES];
   logic                    drop_err_q, drop_err_d;
   logic                    sat_flag_q, sat_flag_d;
   logic [LANES-1:0]        clamp_s;
   logic [ACC_W-1:0]        acc_sel_s;

   // Sign-extend one psum lane to accumulator width.
   function automatic logic [ACC_W-1:0] sext(input logic [PSUM_W-1:0] v);
      sext = {{(ACC_W-PSUM_W){v[PSUM_W-1]}}, v};
   endfunction

   // Saturating signed add: one guard bit detects overflow, which then clamps
   // to the extreme of the sign the true result would have had.
   function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                                input logic [PSUM_W-1:0] b,
                                                output logic clamped);
      logic [ACC_W:0] sum;
      sum = {a[ACC_W-1], a} + {b[PSUM_W-1], sext(b)};
      if (sum[ACC_W] != sum[ACC_W-1]) begin
         clamped = 1'b1;
         sat_add = sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end else begin
         clamped = 1'b0;
         sat_add = sum[ACC_W-1:0];
      end
   endfunction

   // Next-state logic: accumulation in ACCUM, lane sequencing in DRAIN.
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      acc_d      = acc_q;
      drop_err_d = drop_err_q;
      sat_flag_d = sat_flag_q;
      clamp_s    = '0;
      case (state_q)
         ST_ACCUM: begin
            if (psum_valid) begin
               for (int i = 0; i < LANES; i++) begin
                  if (first_ch) begin
                     acc_d[i] = sext(psum_in[i*PSUM_W +: PSUM_W]);
                  end else begin
                     acc_d[i] = sat_add(acc_q[i], psum_in[i*PSUM_W +: PSUM_W], clamp_s[i]);
                  end
               end
               if (|clamp_s) begin
                  sat_flag_d = 1'b1;
               end else begin
                  sat_flag_d = sat_flag_q;
               end
               if (last_ch) begin
                  state_d = ST_DRAIN;
                  idx_d   = 5'd0;
               end else begin
                  state_d = ST_ACCUM;
               end
            end else begin
               state_d = ST_ACCUM;
            end
         end
         ST_DRAIN: begin
            // Beats are not accepted here; they are recorded, never applied.
            if (psum_valid) begin
               drop_err_d = 1'b1;
            end else begin
               drop_err_d = drop_err_q;
            end
            if (out_ready) begin
               if (idx_q == LAST_IDX) begin
                  state_d = ST_ACCUM;
                  idx_d   = 5'd0;
               end else begin
                  idx_d = idx_q + 5'd1;
               end
            end else begin
               idx_d = idx_q;
            end
         end
         default: begin
            state_d = ST_ACCUM;
            idx_d   = 5'd0;
         end
      endcase
   end

   // State registers; accumulators are deliberately not cleared between rows.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_ACCUM;
         idx_q      <= 5'd0;
         drop_err_q <= 1'b0;
         sat_flag_q <= 1'b0;
         for (int i = 0; i < LANES; i++) begin
            acc_q[i] <= '0;
         end
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         drop_err_q <= drop_err_d;
         sat_flag_q <= sat_flag_d;
         for (int i = 0; i < LANES; i++) begin
            acc_q[i] <= acc_d[i];
         end
      end
   end

   assign acc_sel_s = acc_q[idx_q];

   // Output sample select; zero outside DRAIN so the bus is quiet between rows.
   always_comb begin
      out_data = '0;
      if (state_q == ST_DRAIN) begin
`ifdef PSUM_RELU_EN
         if (acc_sel_s[ACC_W-1]) begin
            out_data = '0;
         end else begin
            out_data = acc_sel_s;
         end
`else
         out_data = acc_sel_s;
`endif
      end else begin
         out_data = '0;
      end
   end

   assign psum_ready = (state_q == ST_ACCUM);
   assign out_valid  = (state_q == ST_DRAIN);
   assign out_idx    = idx_q;
   assign out_last   = (state_q == ST_DRAIN) && (idx_q == LAST_IDX);
   assign drop_err   = drop_err_q;
   assign sat_flag   = sat_flag_q;

endmodule

// File: tb/tb_conv_psum_collector.sv
module tb_conv_psum_collector;
   localparam int LANES  = 24;
   localparam int PSUM_W = 20;
   localparam int ACC_W  = 24;

   typedef struct packed {
      logic [ACC_W-1:0] data;
      logic [4:0]       idx;
      logic             last;
   } exp_t;

   logic                    clk;
   logic                    rst;
   logic                    psum_valid;
   logic [LANES*PSUM_W-1:0] psum_in;
   logic                    first_ch;
   logic                    last_ch;
   logic                    psum_ready;
   logic                    out_valid;
   logic                    out_ready;
   logic [ACC_W-1:0]        out_data;
   logic [4:0]              out_idx;
   logic                    out_last;
   logic                    drop_err;
   logic                    sat_flag;

   conv_psum_collector #(.LANES(LANES), .PSUM_W(PSUM_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .psum_valid(psum_valid), .psum_in(psum_in),
      .first_ch(first_ch), .last_ch(last_ch), .psum_ready(psum_ready),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .out_last(out_last), .drop_err(drop_err),
      .sat_flag(sat_flag)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int               errors = 0;
   int               checks = 0;
   int               low_cnt = 0;
   exp_t             exp_q[$];
   exp_t             e;
   logic             hold_v = 1'b0;
   logic [ACC_W-1:0] hold_data;
   logic [4:0]       hold_idx;
   logic [ACC_W-1:0] row [LANES];
   logic [LANES*PSUM_W-1:0] w;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   function automatic logic [LANES*PSUM_W-1:0] fill(input int v);
      logic [LANES*PSUM_W-1:0] f;
      for (int i = 0; i < LANES; i++) f[i*PSUM_W +: PSUM_W] = PSUM_W'(v);
      return f;
   endfunction

   task automatic set_row(input int v);
      for (int i = 0; i < LANES; i++) row[i] = ACC_W'(v);
   endtask

   task automatic push_row();
      exp_t x;
      for (int i = 0; i < LANES; i++) begin
         x.data = row[i];
         x.idx  = 5'(i);
         x.last = (i == LANES - 1);
         exp_q.push_back(x);
      end
   endtask

   task automatic beat(input logic [LANES*PSUM_W-1:0] bw, input logic f, input logic l);
      @(negedge clk);
      psum_in = bw; first_ch = f; last_ch = l; psum_valid = 1'b1;
      @(posedge clk);
      #1;
      psum_valid = 1'b0; first_ch = 1'b0; last_ch = 1'b0;
      if (l) chk("valid_rise", 32'(out_valid), 32'd1);
   endtask

   task automatic wait_accum();
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (psum_ready) break;
      end
      chk("drain_done", 32'(psum_ready), 32'd1);
   endtask

   // Monitor: pops the scoreboard on each handshake, checks hold stability.
   always @(negedge clk) begin
      if (psum_ready === 1'b0) low_cnt++;
      if (!rst && out_valid) begin
         if (hold_v) begin
            chk("hold_data", 32'(out_data), 32'(hold_data));
            chk("hold_idx", 32'(out_idx), 32'(hold_idx));
         end
         if (out_ready) begin
            hold_v = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_output actual idx=%0d data=%0h required=none", out_idx, out_data);
            end else begin
               e = exp_q.pop_front();
               chk("out_data", 32'(out_data), 32'(e.data));
               chk("out_idx", 32'(out_idx), 32'(e.idx));
               chk("out_last", 32'(out_last), 32'(e.last));
            end
         end else begin
            hold_v    = 1'b1;
            hold_data = out_data;
            hold_idx  = out_idx;
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1; psum_valid = 1'b0; psum_in = '0;
      first_ch = 1'b0; last_ch = 1'b0; out_ready = 1'b1;
      #12;
      chk("rst_psum_ready", 32'(psum_ready), 32'd1);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);
      chk("rst_out_idx", 32'(out_idx), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_drop_err", 32'(drop_err), 32'd0);
      chk("rst_sat_flag", 32'(sat_flag), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // 5 then 3 -> 8 in every lane, drain takes 24 cycles
      set_row(8);
      push_row();
      beat(fill(5), 1'b1, 1'b0);
      low_cnt = 0;
      beat(fill(3), 1'b0, 1'b1);
      wait_accum();
      chk("ready_low_cycles", 32'(low_cnt), 32'd24);

      // single-channel group with a negative lane 0
      set_row(0);
`ifdef PSUM_RELU_EN
      row[0] = ACC_W'(0);
`else
      row[0] = ACC_W'(-1000);
`endif
      push_row();
      w = fill(0);
      w[PSUM_W-1:0] = PSUM_W'(-1000);
      beat(w, 1'b1, 1'b1);
      wait_accum();
      chk("sat_after_neg", 32'(sat_flag), 32'd0);

      // three max-positive beats: 1572861, no saturation
      set_row(1572861);
      push_row();
      beat(fill(524287), 1'b1, 1'b0);
      beat(fill(524287), 1'b0, 1'b0);
      beat(fill(524287), 1'b0, 1'b1);
      wait_accum();
      chk("sat_3beats", 32'(sat_flag), 32'd0);

      // 20 more beats onto the held values: clamps at 8388607
      set_row(8388607);
      push_row();
      for (int k = 0; k < 19; k++) beat(fill(524287), 1'b0, 1'b0);
      beat(fill(524287), 1'b0, 1'b1);
      wait_accum();
      chk("sat_20beats", 32'(sat_flag), 32'd1);

      // distinct lanes, out_ready pattern 1,0,0 repeating
      for (int i = 0; i < LANES; i++) begin
         row[i] = ACC_W'(i * 7 + 1);
         w[i*PSUM_W +: PSUM_W] = PSUM_W'(i * 7 + 1);
      end
      push_row();
      beat(w, 1'b1, 1'b1);
      for (int k = 0; k < 300; k++) begin
         out_ready = (k % 3 == 0);
         @(posedge clk);
         #1;
         if (psum_ready) break;
      end
      out_ready = 1'b1;
      chk("toggle_drain_done", 32'(psum_ready), 32'd1);

      // beat during drain is dropped and flagged
      set_row(9);
      push_row();
      beat(fill(9), 1'b1, 1'b1);
      beat(fill(77), 1'b1, 1'b1);
      chk("drop_err_set", 32'(drop_err), 32'd1);
      wait_accum();
      chk("drop_err_sticky", 32'(drop_err), 32'd1);
      set_row(10);
      push_row();
      beat(fill(1), 1'b0, 1'b1);
      wait_accum();

      // reset in the middle of a drain
      set_row(6);
      push_row();
      beat(fill(6), 1'b1, 1'b1);
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (out_valid && out_idx == 5'd10) break;
      end
      chk("reached_idx10", 32'(out_idx), 32'd10);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_out_data", 32'(out_data), 32'd0);
      chk("mid_rst_out_idx", 32'(out_idx), 32'd0);
      chk("mid_rst_out_last", 32'(out_last), 32'd0);
      chk("mid_rst_drop_err", 32'(drop_err), 32'd0);
      chk("mid_rst_sat_flag", 32'(sat_flag), 32'd0);
      chk("mid_rst_psum_ready", 32'(psum_ready), 32'd1);
      exp_q.delete();
      hold_v = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         chk("post_rst_idle", 32'(out_valid), 32'd0);
      end
      // accumulators were cleared, so an add-only group yields the beat value
      set_row(4);
      push_row();
      beat(fill(4), 1'b0, 1'b1);
      wait_accum();

      @(negedge clk);
      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
